// File: rtl/pixel_array_sequencer.sv
// Pixel array sequencer: ERASE/EXPOSE/CONVERT phase control, ramp code,
// per-pixel first-hit capture and row-by-row valid/ready frame readout.
module pixel_array_sequencer #(
  parameter int ROWS          = 2,
  parameter int COLS          = 2,
  parameter int WIDTH         = 8,
  parameter int ERASE_CYCLES  = 5,
  parameter int EXPOSE_CYCLES = 255
) (
  input  logic                                   CLK,
  input  logic                                   RESET_N,
  input  logic                                   START,
  output logic                                   ERASE,
  output logic                                   EXPOSE,
  output logic                                   CONVERT,
  output logic [WIDTH-1:0]                       RAMP,
  input  logic [ROWS*COLS-1:0]                   CMP,
  output logic [COLS*WIDTH-1:0]                  OUT_DATA,
  output logic [((ROWS>1)?$clog2(ROWS):1)-1:0]   OUT_ROW,
  output logic                                   OUT_VALID,
  input  logic                                   OUT_READY,
  output logic                                   BUSY
);

  localparam int NPIX = ROWS * COLS;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int MAXC = (ERASE_CYCLES > EXPOSE_CYCLES) ?
                        ERASE_CYCLES : EXPOSE_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] E_LAST = CW'(ERASE_CYCLES - 1);
  localparam logic [CW-1:0] X_LAST = CW'(EXPOSE_CYCLES - 1);
  localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);

  // One-hot so each phase output is a bare flop bit
  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    ERASE_S   = 5'b00010,
    EXPOSE_S  = 5'b00100,
    CONVERT_S = 5'b01000,
    READ_S    = 5'b10000
  } state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [RW-1:0]     row;
  logic [NPIX-1:0]   flag;
  logic [WIDTH-1:0]  code [NPIX];
  logic              ramp_last;
  logic              row_last;

  assign ERASE     = state[1];
  assign EXPOSE    = state[2];
  assign CONVERT   = state[3];
  assign OUT_VALID = state[4];
  assign BUSY      = ~state[0];
  assign OUT_ROW   = row;
  assign ramp_last = &RAMP;
  assign row_last  = (row == R_LAST);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state[0]: if (START)                 state_nx = ERASE_S;
      state[1]: if (cnt == E_LAST)         state_nx = EXPOSE_S;
      state[2]: if (cnt == X_LAST)         state_nx = CONVERT_S;
      state[3]: if (ramp_last)             state_nx = READ_S;
      state[4]: if (OUT_READY && row_last) state_nx = IDLE;
      default:                             state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)               cnt <= '0;
    else if (state_nx != state) cnt <= '0;
    else if (ERASE || EXPOSE)   cnt <= cnt + CW'(1);
  end

  // Ramp sits at 0 outside CONVERT and wraps to 0 on the last code
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                  RAMP <= '0;
    else if (CONVERT && !ramp_last) RAMP <= RAMP + WIDTH'(1);
    else                           RAMP <= '0;
  end

  // Saturation on the last edge equals a capture at the final code
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      flag <= '0;
      for (int i = 0; i < NPIX; i++) code[i] <= '0;
    end else if (state[0] && START) begin
      flag <= '0;
    end else if (CONVERT) begin
      for (int i = 0; i < NPIX; i++) begin
        if (!flag[i] && (CMP[i] || ramp_last)) begin
          flag[i] <= 1'b1;
          code[i] <= RAMP;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                   row <= '0;
    else if (OUT_VALID && OUT_READY) row <= row_last ? '0 : row + RW'(1);
  end

  always_comb begin
    OUT_DATA = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row == RW'(r)) begin
        for (int c = 0; c < COLS; c++)
          OUT_DATA[c*WIDTH +: WIDTH] = code[r*COLS + c];
      end
    end
  end

endmodule

// File: tb/tb_pixel_array_sequencer.sv
// Directed self-checking bench for pixel_array_sequencer: default 2x2
// instance plus a 3x4, 4-bit instance.
module tb_pixel_array_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a, ready_a;
  logic [3:0]  cmp_a;
  logic        erase_a, expose_a, convert_a, valid_a, busy_a;
  logic [7:0]  ramp_a;
  logic [15:0] data_a;
  logic [0:0]  row_a;

  logic        start_b, ready_b;
  logic [11:0] cmp_b;
  logic        erase_b, expose_b, convert_b, valid_b, busy_b;
  logic [3:0]  ramp_b;
  logic [15:0] data_b;
  logic [1:0]  row_b;

  pixel_array_sequencer u_dut (
    .CLK(clk), .RESET_N(rst_n), .START(start_a),
    .ERASE(erase_a), .EXPOSE(expose_a), .CONVERT(convert_a),
    .RAMP(ramp_a), .CMP(cmp_a), .OUT_DATA(data_a), .OUT_ROW(row_a),
    .OUT_VALID(valid_a), .OUT_READY(ready_a), .BUSY(busy_a)
  );

  pixel_array_sequencer #(
    .ROWS(3), .COLS(4), .WIDTH(4), .ERASE_CYCLES(1), .EXPOSE_CYCLES(1)
  ) u_dut_b (
    .CLK(clk), .RESET_N(rst_n), .START(start_b),
    .ERASE(erase_b), .EXPOSE(expose_b), .CONVERT(convert_b),
    .RAMP(ramp_b), .CMP(cmp_b), .OUT_DATA(data_b), .OUT_ROW(row_b),
    .OUT_VALID(valid_b), .OUT_READY(ready_b), .BUSY(busy_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the first sample with BUSY low
  task automatic run_a(input int thr [4], input bit pulse,
                       input bit stall, input bit poke, input int exp [4]);
    int e_n = 0, x_n = 0, c_n = 0, b_n = 0, beats = 0, j = 0;
    int ramp_bad = 0, oh_bad = 0, hold_bad = 0;
    bit held = 0;
    logic [15:0] hd;
    logic [0:0]  hr;
    cmp_a   = '0;
    ready_a = !stall;
    start_a = 1'b1;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (n == 1) check("erase_first", erase_a, 1'b1);
      if (!busy_a) break;
      b_n++;
      if (erase_a)  e_n++;
      if (expose_a) x_n++;
      if (convert_a) begin
        if (ramp_a != 8'(c_n)) ramp_bad++;
        c_n++;
      end
      if (int'(erase_a) + int'(expose_a) + int'(convert_a)
          + int'(valid_a) != 1) oh_bad++;
      if (poke && ((expose_a && x_n == 100) || (valid_a && j == 0)))
        start_a = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (pulse && i == 0)
          cmp_a[i] = convert_a && (ramp_a == 8'd3 || ramp_a == 8'd50);
        else if (pulse && i == 2)
          cmp_a[i] = 1'b0;
        else
          cmp_a[i] = convert_a && (int'(ramp_a) >= thr[i]);
      end
      if (valid_a) begin
        if (held && (data_a !== hd || row_a !== hr)) hold_bad++;
        ready_a = stall ? (j >= 7 && ((j - 7) % 2 == 0)) : 1'b1;
        j++;
        if (ready_a) begin
          if (beats < 2) begin
            check("beat_row", row_a, beats);
            check("beat_data", data_a,
                  {8'(exp[2*beats+1]), 8'(exp[2*beats])});
          end
          beats++;
          held = 0;
        end else begin
          held = 1;
          hd   = data_a;
          hr   = row_a;
        end
      end
    end
    ready_a = 1'b1;
    cmp_a   = '0;
    check("busy_clks", b_n, 516 + (stall ? 10 : 2));
    check("erase_len", e_n, 5);
    check("expose_len", x_n, 255);
    check("convert_len", c_n, 256);
    check("ramp_seq", ramp_bad, 0);
    check("one_hot", oh_bad, 0);
    check("stall_hold", hold_bad, 0);
    check("beat_count", beats, 2);
  endtask

  task automatic run_b();
    int b_n = 0, c_n = 0, beats = 0;
    ready_b = 1'b1;
    start_b = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (!busy_b) break;
      b_n++;
      if (convert_b) c_n++;
      for (int i = 0; i < 12; i++)
        cmp_b[i] = convert_b && (int'(ramp_b) >= i);
      if (valid_b) begin
        if (beats < 3) begin
          check("b_row", row_b, beats);
          check("b_data", data_b, {4'(4*beats+3), 4'(4*beats+2),
                                   4'(4*beats+1), 4'(4*beats)});
        end
        beats++;
      end
    end
    check("b_convert_len", c_n, 16);
    check("b_beats", beats, 3);
    check("b_busy_clks", b_n, 21);
  endtask

  int thr1 [4] = '{10, 200, 37, 255};
  int exp1 [4] = '{10, 200, 37, 255};
  int exp2 [4] = '{3, 200, 255, 255};

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0; ready_a = 1'b1; cmp_a = '0;
    start_b = 1'b0; ready_b = 1'b1; cmp_b = '0;
    #12;
    check("rst_outs_a", {erase_a, expose_a, convert_a, valid_a, busy_a,
                         ramp_a, data_a, row_a}, 0);
    check("rst_outs_b", {erase_b, expose_b, convert_b, valid_b, busy_b,
                         ramp_b, data_b, row_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", busy_a, 0);

    run_a(thr1, 1'b0, 1'b0, 1'b0, exp1);
    run_a(thr1, 1'b1, 1'b0, 1'b0, exp2);
    run_a(thr1, 1'b0, 1'b1, 1'b1, exp1);
    repeat (3) @(negedge clk);
    check("idle_persist", data_a, 16'hC80A);
    check("idle_row", row_a, 0);

    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 0; k < 2000 && !(convert_a && ramp_a == 8'd120); k++)
      @(negedge clk);
    check("reach_ramp120", ramp_a, 120);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outs", {erase_a, expose_a, convert_a, valid_a,
                             busy_a, ramp_a, data_a, row_a}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_busy", busy_a, 0);
    check("post_rst_erase", erase_a, 0);
    run_a(thr1, 1'b0, 1'b0, 1'b0, exp1);

    @(negedge clk);
    run_b();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_array_sequencer.md
# pixel_array_sequencer

Parametrised controller and digital back-end for a ROWS×COLS digital-pixel-sensor array. It replaces the fixed four-pixel array by generating the global ERASE/EXPOSE/CONVERT phases and the shared ramp code. It latches each pixel's code when that pixel's comparator fires, then streams the frame out row by row over a valid/ready interface. It sits between the analog pixel models, which supply one comparator bit per pixel, and the frame consumer.

## Interface

Parameters:
- ROWS, 2, number of pixel rows (≥1)
- COLS, 2, number of pixel columns (≥1)
- WIDTH, 8, ramp/ADC code width in bits
- ERASE_CYCLES, 5, ERASE phase length in clocks (≥1)
- EXPOSE_CYCLES, 255, EXPOSE phase length in clocks (≥1)

Ports:
- CLK  in  1  single clock; all state updates on the rising edge
- RESET_N  in  1  asynchronous, active-low reset
- START  in  1  frame request; sampled only in IDLE
- ERASE  out  1  pixel erase phase
- EXPOSE  out  1  pixel exposure phase
- CONVERT  out  1  ramp conversion phase
- RAMP  out  WIDTH  current ramp code, valid while CONVERT
- CMP  in  ROWS*COLS  comparator outputs; bit r*COLS+c is pixel (r,c)
- OUT_DATA  out  COLS*WIDTH  one row of codes; column c occupies bits [c*WIDTH +: WIDTH]
- OUT_ROW  out  max(1,$clog2(ROWS))  row index of OUT_DATA
- OUT_VALID  out  1  row beat valid
- OUT_READY  in  1  consumer accepts beat
- BUSY  out  1  high in every state except IDLE

## Operation

- States: IDLE → ERASE_S → EXPOSE_S → CONVERT_S → READ_S → IDLE. The state is one-hot decoded onto ERASE, EXPOSE, CONVERT and OUT_VALID; at most one of these is high.
- IDLE: with START=1 on an edge, the next state is ERASE_S, the phase counter clears, and all capture flags clear. START is ignored in all other states; there is no queueing.
- ERASE_S: lasts exactly ERASE_CYCLES clocks, then goes to EXPOSE_S.
- EXPOSE_S: lasts exactly EXPOSE_CYCLES clocks, then goes to CONVERT_S.
- CONVERT_S: lasts exactly 2^WIDTH clocks.
  - RAMP steps 0, 1, …, 2^WIDTH−1, one code per clock.
  - On each edge, every pixel whose flag is clear and whose CMP bit is 1 stores the current RAMP value and sets its flag.
  - The first capture wins; later CMP activity and glitches are ignored.
- CONVERT_S exit: on the last edge, each pixel still unflagged stores all-ones (2^WIDTH−1). The saturated code is the same value as a capture at the final code.
- READ_S: the row pointer starts at 0.
  - OUT_VALID=1 and OUT_DATA carries the stored row at OUT_ROW.
  - A beat transfers on an edge with OUT_VALID&&OUT_READY, and the pointer then increments.
  - Transfer of row ROWS−1 returns the block to IDLE.
  - OUT_DATA and OUT_ROW hold stable while OUT_VALID&&!OUT_READY.
- Stored codes persist in IDLE until the next START clears the flags. Codes are overwritten only by new captures or by saturation.
- Reset (asynchronous, at any point, including mid-phase or mid-beat):
  - state goes to IDLE;
  - all counters, flags and stored codes go to 0;
  - every output goes to 0 (ERASE, EXPOSE, CONVERT, RAMP, OUT_DATA, OUT_ROW, OUT_VALID, BUSY).
  - Leaving reset requires a fresh START.

## Timing

- START high at edge t in IDLE: ERASE and BUSY are high from t+1 through t+ERASE_CYCLES.
- EXPOSE is high for the next EXPOSE_CYCLES clocks.
- CONVERT is high for the next 2^WIDTH clocks.
- RAMP is registered: RAMP=k during the k-th CONVERT clock (0-based). CMP sampled high at the edge ending that clock stores k.
- OUT_VALID rises on the clock after the last CONVERT clock. With OUT_READY held at 1, each row takes one clock.
- Minimum frame time from START to IDLE: 1+ERASE_CYCLES+EXPOSE_CYCLES+2^WIDTH+ROWS clocks.
- BUSY falls on the clock after the last beat. START may be accepted on that same IDLE clock.
- Outputs are glitch-free registers; there is no combinational path from CMP or OUT_READY to any output.

## Test plan

- Defaults, with CMP bit i rising when RAMP reaches 10, 200, 37, 255 (i=0..3) and OUT_READY=1 → 2 beats: row 0 = {10,200}, row 1 = {37,255}; OUT_ROW 0 then 1; BUSY low 1+5+255+256+2 clocks after the START edge.
- Pixel 2 CMP never rises and pixel 0 CMP pulses at code 3 and again at 50 → pixel 2 reads 255 (saturated); pixel 0 reads 3.
- OUT_READY low for 7 clocks, then toggling 1/0 → OUT_VALID is held, OUT_DATA and OUT_ROW are stable while stalled, no row is skipped or duplicated, and exactly ROWS beats transfer.
- START pulsed during EXPOSE_S and during READ_S → no restart and phase lengths unchanged; START on the first IDLE clock after the last beat starts a new frame immediately.
- RESET_N asserted mid-CONVERT at RAMP=120 → all outputs are 0 asynchronously; after release the block stays in IDLE with BUSY=0 until START.
- ROWS=3, COLS=4, WIDTH=4, ERASE_CYCLES=1, EXPOSE_CYCLES=1 with CMP bit i rising at code i mod 16 → CONVERT lasts 16 clocks and 3 beats are packed correctly per the bit-slice rule.
